// File: rtl/io_gpio_ctrl_if.sv
// Host I/O-space control signals: chip select, strobes and register address.
// The bidirectional data bus stays a plain port on the controller.
interface io_gpio_ctrl_if #(
    parameter int ADDR_WIDTH = 6
);
    logic                  cs;
    logic                  we;
    logic                  oe;
    logic [ADDR_WIDTH-1:0] address;

    modport master (output cs, we, oe, address);
    modport slave  (input  cs, we, oe, address);
endinterface

// File: rtl/io_gpio_ctrl.sv
// Memory-mapped GPIO: per-port DDR/PORT/PIN/PCMSK, shared PCIFR/PCICR, spare addresses are storage.
// Latency: state updates on the falling edge, pins follow register writes combinationally, reads valid after the address-latch edge.
// No backpressure; pin-change interrupt logic present only when GPIO_PCINT_EN is defined.
module io_gpio_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_PORTS  = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    io_gpio_ctrl_if.slave                   bus,
    inout  wire  [DATA_WIDTH-1:0]           data,
    inout  wire  [NUM_PORTS*DATA_WIDTH-1:0] pins,
    output logic                            irq
);
    localparam int DEPTH   = 1 << ADDR_WIDTH;
    localparam int PW      = NUM_PORTS * DATA_WIDTH;
    localparam int PCIFR_A = 4 * NUM_PORTS;
    localparam int PCICR_A = 4 * NUM_PORTS + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]         s1_q, s1_d;
    logic [PW-1:0]         s2_q, s2_d;
    logic [ADDR_WIDTH-1:0] addr_buf_q, addr_buf_d;
    logic [PW-1:0]         ddr_vec;
    logic [PW-1:0]         port_vec;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  wr_en;
    logic                  rd_en;
    logic                  wr_store;

    function automatic logic is_pin_addr(input logic [ADDR_WIDTH-1:0] a);
        return (int'(a) < 4 * NUM_PORTS) && (a[1:0] == 2'b00);
    endfunction

    assign wr_en = bus.cs && bus.we;
    assign rd_en = bus.cs && bus.oe && !bus.we;

    always_comb begin
        ddr_vec  = '0;
        port_vec = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            ddr_vec[p*DATA_WIDTH +: DATA_WIDTH]  = mem_q[4*p+1];
            port_vec[p*DATA_WIDTH +: DATA_WIDTH] = mem_q[4*p+2];
        end
    end

    for (genvar i = 0; i < PW; i++) begin : g_pin
        assign pins[i] = ddr_vec[i] ? port_vec[i] : 1'bz;
    end

`ifdef GPIO_PCINT_EN
    logic [NUM_PORTS-1:0]  pcifr_q, pcifr_d;
    logic [NUM_PORTS-1:0]  pc_set;
    logic [NUM_PORTS-1:0]  pc_clr;
    logic [PW-1:0]         pcmsk_vec;
    logic [PW-1:0]         chg;
    logic [DATA_WIDTH-1:0] pcicr;
    logic                  irq_q, irq_d;

    assign pcicr    = mem_q[PCICR_A];
    assign wr_store = wr_en && !is_pin_addr(bus.address) && (int'(bus.address) != PCIFR_A);

    // A flag set on the same edge as its write-1-clear survives.
    always_comb begin
        pcmsk_vec = '0;
        pc_set    = '0;
        pc_clr    = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            pcmsk_vec[p*DATA_WIDTH +: DATA_WIDTH] = mem_q[4*p+3];
        end
        chg = (s1_q ^ s2_q) & ~ddr_vec & pcmsk_vec;
        for (int p = 0; p < NUM_PORTS; p++) begin
            pc_set[p] = |chg[p*DATA_WIDTH +: DATA_WIDTH];
        end
        if (wr_en && (int'(bus.address) == PCIFR_A)) begin
            pc_clr = data[NUM_PORTS-1:0];
        end
        pcifr_d = (pcifr_q & ~pc_clr) | pc_set;
        irq_d   = |(DATA_WIDTH'(pcifr_q) & pcicr);
        if (reset) begin
            pcifr_d = '0;
            irq_d   = 1'b0;
        end
    end

    always_ff @(negedge clk) begin
        pcifr_q <= pcifr_d;
        irq_q   <= irq_d;
    end

    assign irq = irq_q;
`else
    function automatic logic is_pcint_addr(input logic [ADDR_WIDTH-1:0] a);
        return ((int'(a) < 4 * NUM_PORTS) && (a[1:0] == 2'b11)) ||
               (int'(a) == PCIFR_A) || (int'(a) == PCICR_A);
    endfunction

    assign wr_store = wr_en && !is_pin_addr(bus.address) && !is_pcint_addr(bus.address);
    assign irq      = 1'b0;
`endif

    always_comb begin
        rd_val = mem_q[addr_buf_q];
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (int'(addr_buf_q) == 4 * p) begin
                rd_val = s2_q[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
`ifdef GPIO_PCINT_EN
        if (int'(addr_buf_q) == PCIFR_A) begin
            rd_val = DATA_WIDTH'(pcifr_q);
        end
`else
        if (is_pcint_addr(addr_buf_q)) begin
            rd_val = '0;
        end
`endif
    end

    assign data = rd_en ? rd_val : 'z;

    // PIN is always the synchronised pad level, so outputs read back what is driven.
    always_comb begin
        mem_d      = mem_q;
        addr_buf_d = addr_buf_q;
        s1_d       = pins;
        s2_d       = s1_q;
        if (wr_store) begin
            mem_d[bus.address] = data;
        end
        if (bus.cs && !bus.we) begin
            addr_buf_d = bus.address;
        end
        if (reset) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem_d[a] = '0;
            end
            addr_buf_d = '0;
            s1_d       = '0;
            s2_d       = '0;
        end
    end

    always_ff @(negedge clk) begin
        mem_q      <= mem_d;
        addr_buf_q <= addr_buf_d;
        s1_q       <= s1_d;
        s2_q       <= s2_d;
    end
endmodule

// File: doc/io_gpio_ctrl.md
# io_gpio_ctrl

Parametrised memory-mapped GPIO controller for the CPU's I/O address space, generalising the two-port I/O SRAM to NUM_PORTS ports of DATA_WIDTH pins each. Each port has a direction register (DDR), an output register (PORT), a synchronised input register (PIN) and a pin-change mask (PCMSK). A shared flag/enable pair raises a level interrupt to the core. All I/O addresses not claimed by the map act as plain read/write storage.

## Interface
- DATA_WIDTH, 8, bits per register and pins per port
- ADDR_WIDTH, 6, I/O address width (64 locations)
- NUM_PORTS, 2, number of GPIO ports; 1..DATA_WIDTH, and 4*NUM_PORTS+2 <= 2^ADDR_WIDTH
- clk  input  1  bus clock; all state updates on the falling edge
- reset  input  1  reset, synchronous, active-high
- cs  input  1  chip select
- we  input  1  write enable
- oe  input  1  output enable for reads
- address  input  ADDR_WIDTH  register address
- data  inout  DATA_WIDTH  bidirectional host data bus
- pins  inout  NUM_PORTS*DATA_WIDTH  external pins; port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH]
- irq  output  1  pin-change interrupt request, level, active-high

## Operation
- Register map for port p: PIN = 4p, DDR = 4p+1, PORT = 4p+2, PCMSK = 4p+3. PCIFR = 4*NUM_PORTS; PCICR = 4*NUM_PORTS+1. Higher addresses are general storage.
- Write: cs && we at a falling edge stores data at address, except PIN addresses (read-only, write ignored) and PCIFR (write-1-to-clear per bit).
- Read: cs && !we latches address into addr_buf; data = memory[addr_buf] while cs && oe && !we, else high-Z.
- Pin drive: pins bit i of port p = DDR[i] ? PORT[i] : 1'bz, continuous.
- Input sampling: two-flop synchroniser per pin (s1 <= pin, s2 <= s1); PIN = s2 for every bit, so output bits read back the driven level.
- Pin change: on an edge where s1[i] != s2[i], DDR[i] == 0 and PCMSK[i] == 1, PCIFR[p] is set.
- PCIFR bits >= NUM_PORTS read 0. irq = |(PCIFR & PCICR), registered.
- Simultaneous set and write-1-clear of one PCIFR bit: set wins.
- Changing DDR does not itself set a flag; only a synchroniser difference on a currently-input bit does.

## Timing
- Reset (sampled at falling edge): all registers incl. storage, s1, s2, addr_buf, PCIFR, PCICR = 0; irq = 0; data high-Z; all pins high-Z. Reset mid-transfer aborts it; a write in the same cycle is discarded.
- Register write visible on pins combinationally after the writing edge (0 cycles).
- External pin change sampled at edge k: PIN updated at edge k+1, PCIFR set at edge k+1, irq asserted at edge k+2.
- Read latency: data valid after the edge latching addr_buf; a write followed next cycle by a read of the same address returns the new value.
- Pulses shorter than one clock period may be missed; this is by design.

## Configuration
- GPIO_PCINT_EN defined: PCMSK, PCIFR, PCICR and irq behave as above.
- Undefined: pin-change logic absent; PCMSK/PCIFR/PCICR addresses read 0 and ignore writes; irq tied 0. Synchroniser, PIN, DDR, PORT are unchanged.

## Test plan
- Reset, then read every mapped address -> all 0; pins all Z; irq 0.
- Write DDR0=0x0F, PORT0=0xA5 -> pins[7:0] = 4'bzzzz_0101; PIN0 reads 0x05 after 2 edges; write PIN0=0xFF ignored.
- Drive pins[15:8]=0x3C with DDR1=0 -> PIN1 reads 0x3C two edges later; no flag with PCMSK1=0.
- PCMSK1=0x04, PCICR=0x02, toggle pin 10 -> PCIFR=0x02 at edge k+1, irq=1 at k+2; write PCIFR=0x02 -> irq drops next edge.
- Toggle masked input pin in the same cycle as write-1-clear of its PCIFR bit -> bit stays 1.
- Compile without GPIO_PCINT_EN, repeat scenario 4 -> PCIFR reads 0, irq stays 0.
